// File: rtl/usb_crc16_framer.sv
// USB packet framer: serialises payload bytes LSB first while driving an external
// serial CRC16 engine, then appends the inverted remainder MSB first.
module usb_crc16_framer #(
  parameter int unsigned MAX_LEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic [15:0] crc16_o,
  output logic        crc16_di,
  output logic        crc16_en,
  output logic        crc16_rst_l,
  output logic        tx_bit,
  output logic        tx_valid,
  output logic        tx_eop,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_DATA, S_WAIT, S_CRC} state_e;

  state_e             state_q, state_d;
  logic [7:0]         sreg_q, sreg_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [15:0]        crc_q, crc_d;
  logic [3:0]         crc_cnt_q, crc_cnt_d;

  logic rdy, di, en, rstl, tbit, tval, eop, errp;
  logic at_max;

  assign at_max = (byte_cnt_q == CNT_W'(MAX_LEN));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      last_q     <= 1'b0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      crc_q      <= '0;
      crc_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      last_q     <= last_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      crc_q      <= crc_d;
      crc_cnt_q  <= crc_cnt_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    last_d     = last_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    crc_d      = crc_q;
    crc_cnt_d  = crc_cnt_q;
    rdy        = 1'b0;
    di         = 1'b0;
    en         = 1'b0;
    rstl       = 1'b1;
    tbit       = 1'b0;
    tval       = 1'b0;
    eop        = 1'b0;
    errp       = 1'b0;

    case (state_q)
      S_IDLE: begin
        rdy = 1'b1;
        if (in_valid) begin
          sreg_d     = in_data;
          last_d     = in_last;
          byte_cnt_d = CNT_W'(1);
          bit_cnt_d  = 3'd0;
          state_d    = S_CLR;
        end
      end
      S_CLR: begin
        rstl    = 1'b0;
        state_d = S_DATA;
      end
      S_DATA: begin
        tval      = 1'b1;
        en        = 1'b1;
        tbit      = sreg_q[0];
        di        = sreg_q[0];
        sreg_d    = {1'b0, sreg_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (last_q || at_max) begin
            crc_cnt_d = 4'd0;
            state_d   = S_CRC;
          end else begin
            rdy = 1'b1;
            if (in_valid) begin
              sreg_d     = in_data;
              last_d     = in_last;
              byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        rdy = 1'b1;
        if (in_valid) begin
          sreg_d     = in_data;
          last_d     = in_last;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          bit_cnt_d  = 3'd0;
          state_d    = S_DATA;
        end
      end
      S_CRC: begin
        tval      = 1'b1;
        crc_cnt_d = crc_cnt_q + 4'd1;
        // Remainder is captured once; the first bit bypasses the register
        if (crc_cnt_q == 4'd0) begin
          tbit  = ~crc16_o[15];
          crc_d = {~crc16_o[14:0], 1'b0};
          errp  = at_max && !last_q;
        end else begin
          tbit  = crc_q[15];
          crc_d = {crc_q[14:0], 1'b0};
        end
        if (crc_cnt_q == 4'd15) begin
          eop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset forces every output to its quiet value
  always_comb begin
    in_ready    = rdy  & ~reset;
    crc16_di    = di   & ~reset;
    crc16_en    = en   & ~reset;
    crc16_rst_l = rstl & ~reset;
    tx_bit      = tbit & ~reset;
    tx_valid    = tval & ~reset;
    tx_eop      = eop  & ~reset;
    err         = errp & ~reset;
    busy        = (state_q != S_IDLE) & ~reset;
  end

endmodule

// File: doc/usb_crc16_framer.md
USB_CRC16_FRAMER -- requirements
Module: usb_crc16_framer

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 64, giving the maximum number of payload bytes per packet.
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port in_data  input  8  payload byte.
REQ-005 The block SHALL have port in_valid  input  1  in_data is valid.
REQ-006 The block SHALL have port in_last  input  1  the byte is the last byte of the packet.
REQ-007 The block SHALL have port in_ready  output  1  the block accepts a byte this cycle.
REQ-008 The block SHALL have port crc16_o  input  16  remainder from the downstream crc16 engine.
REQ-009 The block SHALL have port crc16_di  output  1  serial data bit to the crc16 engine.
REQ-010 The block SHALL have port crc16_en  output  1  crc16 engine shift enable.
REQ-011 The block SHALL have port crc16_rst_l  output  1  active-low clear for the crc16 engine.
REQ-012 The block SHALL have port tx_bit  output  1  serial line bit.
REQ-013 The block SHALL have port tx_valid  output  1  tx_bit is valid.
REQ-014 The block SHALL have port tx_eop  output  1  one-cycle pulse coincident with the final CRC bit.
REQ-015 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 The block SHALL have port err  output  1  one-cycle pulse when a packet is truncated at MAX_LEN.

Function
REQ-017 The state machine SHALL have states IDLE, CLR, DATA, WAIT and CRC.
REQ-018 IDLE behaviour SHALL be as follows.
- in_ready = 1.
- On in_valid: load in_data into the shift register, latch in_last, set byte_cnt = 1, go to CLR.
REQ-019 CLR SHALL last exactly one cycle.
- crc16_rst_l = 0, in_ready = 0, tx_valid = 0.
- Next state is DATA.
REQ-020 DATA behaviour SHALL be as follows each cycle.
- tx_valid = 1, crc16_en = 1.
- tx_bit = crc16_di = shift register bit 0 (LSB first).
- Shift the register right by one and increment bit_cnt.
REQ-021 At bit_cnt = 7 of a byte that is neither last nor the MAX_LEN-th byte, in_ready SHALL be 1.
- If in_valid: load the next byte, increment byte_cnt, and stay in DATA with no gap.
- Otherwise go to WAIT.
REQ-022 WAIT behaviour SHALL be as follows.
- tx_valid = 0, crc16_en = 0, in_ready = 1.
- On in_valid: load the byte, increment byte_cnt, go to DATA.
REQ-023 At bit_cnt = 7 of a last byte, or of the MAX_LEN-th byte, the next state SHALL be CRC and in_ready SHALL be 0.
REQ-024 When byte MAX_LEN is sent without in_last, err SHALL pulse in the first CRC cycle; any following bytes are held upstream and form a new packet.
REQ-025 CRC behaviour SHALL be as follows.
- In the first cycle, tx_bit = ~crc16_o[15] and the 16-bit register is loaded with ~crc16_o.
- Then send bits 15..0, MSB first, for 16 cycles with tx_valid = 1 and crc16_en = 0.
- tx_eop = 1 on the 16th cycle.
- Next state is IDLE.
REQ-026 crc16_o SHALL be sampled only in the first CRC cycle; later changes have no effect.
REQ-027 in_ready SHALL be 0 in CLR, in CRC, and in DATA except at the cycle given in REQ-021.
REQ-028 in_last SHALL be ignored unless in_valid and in_ready are both 1.
REQ-029 Latency SHALL be as follows.
- A byte accepted in IDLE at cycle T gives the first tx_bit at T+2.
- A packet of N bytes with no underrun gives exactly 8N+16 contiguous tx_valid cycles.
REQ-030 crc16_di SHALL be 0 whenever crc16_en = 0.
REQ-031 tx_bit SHALL be 0 whenever tx_valid = 0.

Reset
REQ-032 While reset = 1, the block SHALL go to IDLE on the next edge and clear byte_cnt, bit_cnt and all shift registers.
REQ-033 While reset = 1, the outputs SHALL be: in_ready = 0, crc16_rst_l = 0, crc16_di = 0, crc16_en = 0, tx_bit = 0, tx_valid = 0, tx_eop = 0, busy = 0, err = 0.
REQ-034 Reset asserted in any state SHALL abort the packet with no tx_eop or err, and in_ready SHALL be 1 in the first cycle after reset falls.

Verification
REQ-035 Reset: assert reset for 3 cycles in the middle of DATA -> all outputs take their REQ-033 values; in_ready = 1 one cycle after release; no tx_eop.
REQ-036 Single byte: 0xB4 with in_last and crc16_o stub = 0xA5F0 -> crc16_rst_l low exactly 1 cycle; tx_bit 0,0,1,0,1,1,0,1 with crc16_en high for exactly those 8 cycles; then 0,1,0,1,1,0,1,0,0,0,0,0,1,1,1,1; tx_eop on bit 24.
REQ-037 Back-to-back: 0x01, 0x80, 0xFF (last) with in_valid held high -> 24 contiguous data bits, 16 CRC bits, 40 tx_valid cycles with no gap; in_ready high only on the 3 accept cycles.
REQ-038 Underrun: second byte presented 5 cycles after the first byte's bit 7 -> exactly 5 cycles with tx_valid = 0 and crc16_en = 0, then DATA resumes; crc16_o stub sampled once.
REQ-039 Overlength: MAX_LEN = 4, 5 bytes without in_last -> CRC follows byte 4; err pulses once; byte 5 is held until IDLE and then starts a new packet with a new crc16_rst_l pulse.
REQ-040 Backpressure: in_valid held high during CRC -> in_ready = 0 for all 16 CRC cycles; the byte is accepted in the IDLE cycle after tx_eop.
